// File: rtl/graphics_pkg.sv
// Shared graphics types: default viewport size, iterator state and screen-space coordinate types.
package graphics_pkg;

  localparam int HRES_DEFAULT    = 320;
  localparam int VRES_DEFAULT    = 180;
  localparam int X_WIDTH_DEFAULT = 18;
  localparam int Y_WIDTH_DEFAULT = 20;

  typedef enum logic [1:0] {IDLE, SETUP, ITER} state_e;

  // Screen-space positions carry one extra bit so the viewport offset cannot overflow.
  typedef logic signed [X_WIDTH_DEFAULT:0] scr_x_t;
  typedef logic signed [Y_WIDTH_DEFAULT:0] scr_y_t;

  typedef logic [$clog2(HRES_DEFAULT)-1:0] hcount_t;
  typedef logic [$clog2(VRES_DEFAULT)-1:0] vcount_t;

endpackage

// File: rtl/min_max3.sv
// Combinational signed minimum and maximum of three values.
module min_max3 #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] c_i,
  output logic signed [WIDTH-1:0] min_o,
  output logic signed [WIDTH-1:0] max_o
);

  always_comb begin
    min_o = a_i;
    max_o = a_i;
    if (b_i < min_o) min_o = b_i;
    if (b_i > max_o) max_o = b_i;
    if (c_i < min_o) min_o = c_i;
    if (c_i > max_o) max_o = c_i;
  end

endmodule

// File: rtl/tri_bbox_iter.sv
// Accepts one triangle, computes its viewport-clamped bounding box and streams every
// pixel of the box row-major to the rasterizer with the triangle data held alongside.
module tri_bbox_iter
  import graphics_pkg::*;
#(
  parameter int X_WIDTH     = X_WIDTH_DEFAULT,
  parameter int Y_WIDTH     = Y_WIDTH_DEFAULT,
  parameter int ZWIDTH      = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int HRES        = HRES_DEFAULT,
  parameter int VRES        = VRES_DEFAULT
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  input  logic [2:0][X_WIDTH-1:0]           x_in,
  input  logic [2:0][Y_WIDTH-1:0]           y_in,
  input  logic [2:0][ZWIDTH-1:0]            z_in,
  input  logic [COLOR_WIDTH-1:0]            color_in,
  input  logic                              ready_in,
  output logic                              valid_out,
  output logic [$clog2(HRES)-1:0]           hcount_out,
  output logic [$clog2(VRES)-1:0]           vcount_out,
  output logic [2:0][X_WIDTH-1:0]           x_out,
  output logic [2:0][Y_WIDTH-1:0]           y_out,
  output logic [2:0][ZWIDTH-1:0]            z_out,
  output logic [COLOR_WIDTH-1:0]            color_out,
  output logic                              last_out
);

  localparam int SXW = X_WIDTH + 1;
  localparam int SYW = Y_WIDTH + 1;
  localparam int HW  = $clog2(HRES);
  localparam int VW  = $clog2(VRES);

  localparam logic [SXW-1:0]        XHalf = SXW'(HRES / 2);
  localparam logic [SYW-1:0]        YHalf = SYW'(VRES / 2);
  localparam logic signed [SXW-1:0] XLast = SXW'(HRES - 1);
  localparam logic signed [SYW-1:0] YLast = SYW'(VRES - 1);

  state_e                   state_q, state_d;
  logic [2:0][SXW-1:0]      sx_q, sx_d;
  logic [2:0][SYW-1:0]      sy_q, sy_d;
  logic [2:0][ZWIDTH-1:0]   z_q, z_d;
  logic [COLOR_WIDTH-1:0]   color_q, color_d;
  logic [HW-1:0]            xmin_q, xmin_d, xmax_q, xmax_d, h_q, h_d;
  logic [VW-1:0]            ymin_q, ymin_d, ymax_q, ymax_d, v_q, v_d;
  logic                     valid_q, valid_d;

  logic signed [SXW-1:0]    minx, maxx, xlo, xhi;
  logic signed [SYW-1:0]    miny, maxy, ylo, yhi;
  logic                     cull, at_last;

  min_max3 #(.WIDTH(SXW)) u_mm_x (
    .a_i   (sx_q[0]),
    .b_i   (sx_q[1]),
    .c_i   (sx_q[2]),
    .min_o (minx),
    .max_o (maxx)
  );

  min_max3 #(.WIDTH(SYW)) u_mm_y (
    .a_i   (sy_q[0]),
    .b_i   (sy_q[1]),
    .c_i   (sy_q[2]),
    .min_o (miny),
    .max_o (maxy)
  );

  // Clamp to the viewport in full signed width; an inverted range means nothing is visible.
  always_comb begin
    xlo  = minx[SXW-1] ? '0 : minx;
    xhi  = (maxx > XLast) ? XLast : maxx;
    ylo  = miny[SYW-1] ? '0 : miny;
    yhi  = (maxy > YLast) ? YLast : maxy;
    cull = (xlo > xhi) || (ylo > yhi);
  end

  assign at_last = (h_q == xmax_q) && (v_q == ymax_q);

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    z_d     = z_q;
    color_d = color_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    h_d     = h_q;
    v_d     = v_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          for (int i = 0; i < 3; i++) begin
            sx_d[i] = {x_in[i][X_WIDTH-1], x_in[i]} + XHalf;
            sy_d[i] = {y_in[i][Y_WIDTH-1], y_in[i]} + YHalf;
          end
          z_d     = z_in;
          color_d = color_in;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cull) begin
          state_d = IDLE;
        end else begin
          xmin_d  = xlo[HW-1:0];
          xmax_d  = xhi[HW-1:0];
          ymin_d  = ylo[VW-1:0];
          ymax_d  = yhi[VW-1:0];
          h_d     = xlo[HW-1:0];
          v_d     = ylo[VW-1:0];
          valid_d = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (valid_q && ready_in) begin
          if (at_last) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else if (h_q == xmax_q) begin
            h_d = xmin_q;
            v_d = v_q + VW'(1);
          end else begin
            h_d = h_q + HW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      z_q     <= '0;
      color_q <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      h_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      z_q     <= z_d;
      color_q <= color_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      h_q     <= h_d;
      v_q     <= v_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      x_out[i] = sx_q[i][X_WIDTH-1:0];
      y_out[i] = sy_q[i][Y_WIDTH-1:0];
    end
  end

  assign ready_out  = (state_q == IDLE);
  assign valid_out  = valid_q;
  assign hcount_out = h_q;
  assign vcount_out = v_q;
  assign z_out      = z_q;
  assign color_out  = color_q;
  assign last_out   = valid_q && at_last;

endmodule

// File: tb/tb_tri_bbox_iter.sv
// Directed bench for tri_bbox_iter: small box, backpressure, cull, clamp, point, mid-stream reset.
module tb_tri_bbox_iter;

  localparam int XW   = 18;
  localparam int YW   = 20;
  localparam int ZW   = 16;
  localparam int CW   = 16;
  localparam int HRES = 320;
  localparam int VRES = 180;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [2:0][XW-1:0]     x_in;
  logic [2:0][YW-1:0]     y_in;
  logic [2:0][ZW-1:0]     z_in;
  logic [CW-1:0]          color_in;
  logic                   ready_in;
  logic                   valid_out;
  logic [HW-1:0]          hcount_out;
  logic [VW-1:0]          vcount_out;
  logic [2:0][XW-1:0]     x_out;
  logic [2:0][YW-1:0]     y_out;
  logic [2:0][ZW-1:0]     z_out;
  logic [CW-1:0]          color_out;
  logic                   last_out;

  int n_tests = 0;
  int n_fail  = 0;

  tri_bbox_iter #(
    .X_WIDTH     (XW),
    .Y_WIDTH     (YW),
    .ZWIDTH      (ZW),
    .COLOR_WIDTH (CW),
    .HRES        (HRES),
    .VRES        (VRES)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .x_in       (x_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .color_in   (color_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .color_out  (color_out),
    .last_out   (last_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents a triangle for one accept edge, then leaves the bench in the SETUP cycle.
  task automatic send_tri(input int x0, input int x1, input int x2,
                          input int y0, input int y1, input int y2);
    x_in[0]  = XW'(x0);
    x_in[1]  = XW'(x1);
    x_in[2]  = XW'(x2);
    y_in[0]  = YW'(y0);
    y_in[1]  = YW'(y1);
    y_in[2]  = YW'(y2);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    x_in     = '0;
    y_in     = '0;
  endtask

  // Walks the expected raster order; bp=1 drives ready_in as 1,0,0,1,0,0,...
  task automatic expect_pixels(input string tag, input int xl, input int xh,
                               input int yl, input int yh, input bit bp);
    int  h = xl;
    int  v = yl;
    bit  done = 1'b0;
    bit  rdy;
    int  hs = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      rdy      = bp ? ((cyc % 3) == 0) : 1'b1;
      ready_in = rdy;
      check({tag, " valid"}, 32'(valid_out), 32'd1);
      check({tag, " hcount"}, 32'(hcount_out), 32'(h));
      check({tag, " vcount"}, 32'(vcount_out), 32'(v));
      check({tag, " last"}, 32'(last_out), 32'((h == xh) && (v == yh)));
      check({tag, " ready_out"}, 32'(ready_out), 32'd0);
      tick();
      if (rdy) begin
        hs++;
        if (h == xh && v == yh) done = 1'b1;
        else if (h == xh) begin
          h = xl;
          v++;
        end else h++;
      end
    end
    check({tag, " handshakes"}, 32'(hs), 32'((xh - xl + 1) * (yh - yl + 1)));
    ready_in = 1'b1;
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b1;
    x_in     = '0;
    y_in     = '0;
    z_in     = {16'd300, 16'd200, 16'd100};
    color_in = 16'hBEEF;
    #12;
    check("rst ready_out", 32'(ready_out), 32'd1);
    check("rst valid_out", 32'(valid_out), 32'd0);
    check("rst hcount", 32'(hcount_out), 32'd0);
    check("rst vcount", 32'(vcount_out), 32'd0);
    check("rst last", 32'(last_out), 32'd0);
    check("rst x_out0", 32'(x_out[0]), 32'd0);
    check("rst color", 32'(color_out), 32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Small box: sx 158..161, sy 89..91, 12 pixels, ready_out back at t+14
    send_tri(-2, 0, 1, -1, 0, 1);
    check("small setup ready", 32'(ready_out), 32'd0);
    check("small setup valid", 32'(valid_out), 32'd0);
    tick();
    check("small x_out0", 32'(x_out[0]), 32'd158);
    check("small x_out2", 32'(x_out[2]), 32'd161);
    check("small y_out2", 32'(y_out[2]), 32'd91);
    check("small z_out1", 32'(z_out[1]), 32'd200);
    check("small color", 32'(color_out), 32'hBEEF);
    expect_pixels("small", 158, 161, 89, 91, 1'b0);
    check("small done ready", 32'(ready_out), 32'd1);
    check("small done valid", 32'(valid_out), 32'd0);

    // Backpressure on the same triangle
    send_tri(-2, 0, 1, -1, 0, 1);
    tick();
    expect_pixels("bp", 158, 161, 89, 91, 1'b1);
    check("bp done ready", 32'(ready_out), 32'd1);
    check("bp done valid", 32'(valid_out), 32'd0);

    // Cull: box entirely left of the viewport
    send_tri(-200, -190, -185, 0, 0, 0);
    check("cull setup ready", 32'(ready_out), 32'd0);
    check("cull setup valid", 32'(valid_out), 32'd0);
    tick();
    check("cull t2 ready", 32'(ready_out), 32'd1);
    check("cull t2 valid", 32'(valid_out), 32'd0);
    tick();
    check("cull t3 valid", 32'(valid_out), 32'd0);

    // Clamp: sx -10..2 -> 0..2, sy 0..1
    send_tri(-170, -158, -158, -90, -90, -89);
    tick();
    expect_pixels("clamp", 0, 2, 0, 1, 1'b0);
    check("clamp done ready", 32'(ready_out), 32'd1);

    // Single point
    send_tri(5, 5, 5, 5, 5, 5);
    tick();
    expect_pixels("point", 165, 165, 95, 95, 1'b0);
    check("point done ready", 32'(ready_out), 32'd1);
    check("point done valid", 32'(valid_out), 32'd0);

    // Reset after the third pixel of the small box
    send_tri(-2, 0, 1, -1, 0, 1);
    tick();
    ready_in = 1'b1;
    tick();
    tick();
    tick();
    check("pre-rst hcount", 32'(hcount_out), 32'd161);
    check("pre-rst valid", 32'(valid_out), 32'd1);
    rst_in = 1'b1;
    #1;
    check("mid-rst valid", 32'(valid_out), 32'd0);
    check("mid-rst ready", 32'(ready_out), 32'd1);
    tick();
    rst_in = 1'b0;
    tick();
    check("post-rst valid", 32'(valid_out), 32'd0);
    send_tri(5, 5, 5, 5, 5, 5);
    tick();
    expect_pixels("post-rst point", 165, 165, 95, 95, 1'b0);
    check("post-rst done ready", 32'(ready_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
